// File: rtl/next_pc_unit.sv
// Next-PC stage: branch/jump/jr sequencing with an optional overflow trap (EPC, eret, double-fault
// halt) enabled by defining NEXT_PC_OVF_TRAP_EN.
module next_pc_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_eq,
  input  logic        branch_ne,
  input  logic        jump,
  input  logic        jump_reg,
  input  logic [31:0] imm,
  input  logic [25:0] jidx,
  input  logic [31:0] rs_dat,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        ovf_trap,
  input  logic        eret,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc,
  output logic        in_trap,
  output logic        halted,
  output logic        fetch_valid
);

  typedef enum logic [1:0] {StBoot, StRun, StTrap, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        in_trap_q, halted_q, fetch_valid_q;
  logic        branch_taken;
  logic [31:0] seq_pc;

  assign pc_plus4     = pc_q + 32'd4;
  assign branch_taken = (branch_eq & alu_zero) | (branch_ne & ~alu_zero);

  always_comb begin
    seq_pc = pc_plus4;
    if (jump_reg) begin
      seq_pc = {rs_dat[31:2], 2'b00};
    end else if (jump) begin
      seq_pc = {pc_plus4[31:28], jidx, 2'b00};
    end else if (branch_taken) begin
      seq_pc = pc_plus4 + {imm[29:0], 2'b00};
    end
  end

`ifdef NEXT_PC_OVF_TRAP_EN
  logic trap_cond;
  assign trap_cond = ovf_trap & alu_overflow & ~stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (trap_cond) begin
          state_d = StTrap;
          pc_d    = TRAP_VEC;
          epc_d   = pc_q;
        end else if (!stall) begin
          pc_d = seq_pc;
        end
      end
      StTrap: begin
        // A fault inside the handler is unrecoverable: freeze where it happened.
        if (trap_cond) begin
          state_d = StHalt;
        end else if (!stall) begin
          if (eret) begin
            state_d = StRun;
            pc_d    = epc_q;
          end else begin
            pc_d = seq_pc;
          end
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StBoot;
    endcase
  end
`else
  logic unused_trap_inputs;
  assign unused_trap_inputs = ^{ovf_trap, alu_overflow, eret, TRAP_VEC};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = 32'h0;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun: begin
        if (!stall) begin
          pc_d = seq_pc;
        end
      end
      default: state_d = StBoot;
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StBoot;
      pc_q          <= RESET_VEC;
      epc_q         <= 32'h0;
      in_trap_q     <= 1'b0;
      halted_q      <= 1'b0;
      fetch_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      in_trap_q     <= (state_d == StTrap);
      halted_q      <= (state_d == StHalt);
      fetch_valid_q <= (state_d == StRun) || (state_d == StTrap);
    end
  end

  assign pc          = pc_q;
  assign epc         = epc_q;
  assign in_trap     = in_trap_q;
  assign halted      = halted_q;
  assign fetch_valid = fetch_valid_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit; trap scenarios follow NEXT_PC_OVF_TRAP_EN.
module tb_next_pc_unit;

  logic        clk = 1'b0;
  logic        rst, stall, branch_eq, branch_ne, jump, jump_reg;
  logic [31:0] imm, rs_dat;
  logic [25:0] jidx;
  logic        alu_zero, alu_overflow, ovf_trap, eret;
  logic [31:0] pc, pc_plus4, epc;
  logic        in_trap, halted, fetch_valid;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_pc;

  next_pc_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_eq(branch_eq), .branch_ne(branch_ne),
    .jump(jump), .jump_reg(jump_reg), .imm(imm), .jidx(jidx), .rs_dat(rs_dat),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .ovf_trap(ovf_trap), .eret(eret),
    .pc(pc), .pc_plus4(pc_plus4), .epc(epc), .in_trap(in_trap), .halted(halted),
    .fetch_valid(fetch_valid)
  );

  always #5 clk = ~clk;

  task automatic clear_ctrl();
    stall = 0; branch_eq = 0; branch_ne = 0; jump = 0; jump_reg = 0;
    imm = '0; jidx = '0; rs_dat = '0; alu_zero = 0; alu_overflow = 0; ovf_trap = 0; eret = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steer the PC with a jr; not a comparison.
  task automatic goto_pc(input logic [31:0] a);
    clear_ctrl();
    jump_reg = 1; rs_dat = a;
    tick();
    clear_ctrl();
  endtask

  task automatic test_reset();
    rst = 1; clear_ctrl();
    tick();
    checks++;
    if (pc !== 32'h0 || epc !== 32'h0 || in_trap !== 0 || halted !== 0 || fetch_valid !== 0) begin
      errors++;
      $display("FAIL reset: pc=%h epc=%h trap=%b halt=%b fv=%b, want 0 0 0 0 0",
               pc, epc, in_trap, halted, fetch_valid);
    end
    rst = 0;
    sb_q.push_back(32'h0); sb_q.push_back(32'h4); sb_q.push_back(32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = sb_q.pop_front();
      checks++;
      if (pc !== exp_pc || fetch_valid !== 1'b1) begin
        errors++;
        $display("FAIL boot_seq[%0d]: pc=%h fv=%b, want pc=%h fv=1", i, pc, fetch_valid, exp_pc);
      end
    end
  endtask

  task automatic test_branch();
    for (int z = 1; z >= 0; z--) begin
      goto_pc(32'h40);
      branch_eq = 1; alu_zero = z[0]; imm = 32'hFFFF_FFFE;
      sb_q.push_back(z == 1 ? 32'h3C : 32'h44);
      tick();
      exp_pc = sb_q.pop_front();
      checks++;
      if (pc !== exp_pc) begin
        errors++;
        $display("FAIL beq zero=%0d: pc=%h, want %h", z, pc, exp_pc);
      end
    end
    goto_pc(32'h40);
    branch_ne = 1; alu_zero = 0; imm = 32'h0000_0003;
    sb_q.push_back(32'h50);
    tick();
    exp_pc = sb_q.pop_front();
    checks++;
    if (pc !== exp_pc) begin
      errors++;
      $display("FAIL bne taken: pc=%h, want %h", pc, exp_pc);
    end
  endtask

  task automatic test_jump();
    goto_pc(32'h1000_0010);
    jump = 1; jidx = 26'h10;
    sb_q.push_back(32'h1000_0040);
    tick();
    exp_pc = sb_q.pop_front();
    checks++;
    if (pc !== exp_pc) begin
      errors++;
      $display("FAIL jump: pc=%h, want %h", pc, exp_pc);
    end
    goto_pc(32'h1000_0010);
    jump = 1; jidx = 26'h10; jump_reg = 1; rs_dat = 32'h203; branch_eq = 1; alu_zero = 1;
    sb_q.push_back(32'h200);
    tick();
    exp_pc = sb_q.pop_front();
    checks++;
    if (pc !== exp_pc) begin
      errors++;
      $display("FAIL jr_priority: pc=%h, want %h", pc, exp_pc);
    end
  endtask

`ifdef NEXT_PC_OVF_TRAP_EN
  task automatic test_trap();
    goto_pc(32'h80);
    ovf_trap = 1; alu_overflow = 1; jump = 1; jidx = 26'h55;
    sb_q.push_back(32'h180);
    tick();
    exp_pc = sb_q.pop_front();
    checks++;
    if (pc !== exp_pc || epc !== 32'h80 || in_trap !== 1'b1) begin
      errors++;
      $display("FAIL trap_entry: pc=%h epc=%h trap=%b, want %h 00000080 1", pc, epc, in_trap, exp_pc);
    end
    clear_ctrl();
    eret = 1;
    sb_q.push_back(32'h80);
    tick();
    exp_pc = sb_q.pop_front();
    checks++;
    if (pc !== exp_pc || in_trap !== 1'b0) begin
      errors++;
      $display("FAIL eret: pc=%h trap=%b, want %h 0", pc, in_trap, exp_pc);
    end
  endtask

  task automatic test_double_fault();
    clear_ctrl();
    ovf_trap = 1; alu_overflow = 1;
    tick();
    tick();
    checks++;
    if (halted !== 1'b1 || fetch_valid !== 1'b0 || pc !== 32'h180) begin
      errors++;
      $display("FAIL halt_entry: halt=%b fv=%b pc=%h, want 1 0 00000180", halted, fetch_valid, pc);
    end
    for (int i = 0; i < 10; i++) begin
      stall = i[0]; jump_reg = 1; rs_dat = 32'h700 + i; eret = i[1];
      tick();
      checks++;
      if (pc !== 32'h180 || epc !== 32'h80 || halted !== 1'b1) begin
        errors++;
        $display("FAIL halt_frozen[%0d]: pc=%h epc=%h halt=%b", i, pc, epc, halted);
      end
    end
    rst = 1;
    tick();
    rst = 0; clear_ctrl();
    checks++;
    if (pc !== 32'h0 || halted !== 0 || fetch_valid !== 0 || epc !== 32'h0) begin
      errors++;
      $display("FAIL halt_reset: pc=%h halt=%b fv=%b epc=%h, want 0 0 0 0", pc, halted, fetch_valid, epc);
    end
    tick();
  endtask
`else
  task automatic test_trap_disabled();
    goto_pc(32'h80);
    ovf_trap = 1; alu_overflow = 1; eret = 1;
    sb_q.push_back(32'h84);
    tick();
    exp_pc = sb_q.pop_front();
    checks++;
    if (pc !== exp_pc || epc !== 32'h0 || in_trap !== 0 || halted !== 0) begin
      errors++;
      $display("FAIL trap_ignored: pc=%h epc=%h trap=%b halt=%b, want %h 0 0 0",
               pc, epc, in_trap, halted, exp_pc);
    end
  endtask
`endif

  task automatic test_stall_wrap();
    goto_pc(32'h100);
    stall = 1; ovf_trap = 1; alu_overflow = 1; jump_reg = 1; rs_dat = 32'h500;
    sb_q.push_back(32'h100);
    tick();
    exp_pc = sb_q.pop_front();
    checks++;
    if (pc !== exp_pc || epc !== 32'h0 || in_trap !== 0) begin
      errors++;
      $display("FAIL stall_trap: pc=%h epc=%h trap=%b, want %h 0 0", pc, epc, in_trap, exp_pc);
    end
    clear_ctrl();
    sb_q.push_back(32'h104);
    tick();
    exp_pc = sb_q.pop_front();
    checks++;
    if (pc !== exp_pc || in_trap !== 0) begin
      errors++;
      $display("FAIL stall_release: pc=%h trap=%b, want %h 0", pc, in_trap, exp_pc);
    end
    goto_pc(32'hFFFF_FFFC);
    sb_q.push_back(32'h0);
    tick();
    exp_pc = sb_q.pop_front();
    checks++;
    if (pc !== exp_pc) begin
      errors++;
      $display("FAIL wrap: pc=%h, want %h", pc, exp_pc);
    end
  endtask

  task automatic test_back_to_back();
    // op: 0 nop, 1 bne, 2 beq, 3 jump
    int          op_t[5]  = '{1, 0, 2, 3, 2};
    logic        zero_t[5] = '{0, 0, 0, 0, 1};
    logic [31:0] imm_t[5] = '{32'h4, 32'h0, 32'h8, 32'h0, 32'h10};
    logic [31:0] exp_t[5] = '{32'h214, 32'h218, 32'h21C, 32'h0000_000C, 32'h50};
    goto_pc(32'h200);
    for (int i = 0; i < 5; i++) begin
      clear_ctrl();
      branch_ne = (op_t[i] == 1); branch_eq = (op_t[i] == 2); jump = (op_t[i] == 3);
      jidx = 26'h3; alu_zero = zero_t[i]; imm = imm_t[i];
      sb_q.push_back(exp_t[i]);
      tick();
      exp_pc = sb_q.pop_front();
      checks++;
      if (pc !== exp_pc || pc_plus4 !== exp_pc + 32'd4) begin
        errors++;
        $display("FAIL b2b[%0d]: pc=%h pc4=%h, want %h", i, pc, pc_plus4, exp_pc);
      end
    end
    clear_ctrl();
  endtask

  initial begin
    clear_ctrl();
    rst = 1;
    test_reset();
    test_branch();
    test_jump();
`ifdef NEXT_PC_OVF_TRAP_EN
    test_trap();
    test_double_fault();
`else
    test_trap_disabled();
`endif
    test_stall_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Program-counter stage directly downstream of the ALU in the single-cycle CPU. It consumes the ALU `zero` and `overflow` flags together with the decoder's control and immediate fields, and computes and registers the next PC. It also owns the arithmetic-overflow trap: it saves the EPC, vectors to the trap handler, returns on `eret`, and halts on a double fault. Its `pc` output drives instruction-memory address generation.

## Interface
- `RESET_VEC`, 32'h0000_0000, PC value loaded by reset.
- `TRAP_VEC`, 32'h0000_0180, overflow-trap handler address.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `stall`  in  1  hold all state this cycle; the instruction does not commit.
- `branch_eq`  in  1  beq: taken when `alu_zero`=1.
- `branch_ne`  in  1  bne: taken when `alu_zero`=0.
- `jump`  in  1  j/jal.
- `jump_reg`  in  1  jr.
- `imm`  in  32  sign-extended 16-bit branch offset, in words.
- `jidx`  in  26  jump index field.
- `rs_dat`  in  32  register value for jr.
- `alu_zero`  in  1  ALU zero flag.
- `alu_overflow`  in  1  ALU overflow flag.
- `ovf_trap`  in  1  current instruction is signed add/sub, so overflow traps.
- `eret`  in  1  return from trap.
- `pc`  out  32  current PC (registered).
- `pc_plus4`  out  32  `pc`+4 (combinational), used for jal link.
- `epc`  out  32  saved PC of the trapping instruction (registered).
- `in_trap`  out  1  FSM is in TRAP.
- `halted`  out  1  FSM is in HALT (double fault).
- `fetch_valid`  out  1  0 during BOOT and HALT; 1 otherwise.

## Operation
- FSM states: BOOT, RUN, TRAP, HALT.
  - BOOT → RUN unconditionally after one cycle, to cover instruction-memory latency. PC holds during BOOT.
  - RUN: normal sequencing. A trap condition moves the FSM to TRAP.
  - TRAP: normal sequencing inside the handler. `eret` → RUN. A trap condition → HALT.
  - HALT: PC and EPC frozen; all inputs ignored until `rst`.
- Trap condition is `ovf_trap & alu_overflow & ~stall`.
- Next-PC priority, evaluated only in RUN/TRAP with `stall`=0:
  1. trap (RUN only) → `TRAP_VEC`, and `epc` <= `pc`.
  2. `eret` (TRAP only) → `epc`. In RUN, `eret` is a no-op and the PC advances +4.
  3. `jump_reg` → {`rs_dat`[31:2], 2'b00}. Misaligned low bits are silently cleared.
  4. `jump` → {`pc_plus4`[31:28], `jidx`, 2'b00}.
  5. taken branch → `pc_plus4` + (`imm` << 2).
  6. otherwise → `pc_plus4`.
- Arithmetic is 32-bit, modulo 2^32. Wrap-around at 32'hFFFF_FFFC + 4 → 0 is not an error. Negative `imm` wraps likewise.
- If more than one of `jump`, `jump_reg` and branch is asserted at once, the priority above resolves it.
- `stall` freezes `pc`, `epc` and FSM state. Overflow raised during a stall is ignored.

## Timing
- Reset values (one edge with `rst`=1):
  - `pc`=`RESET_VEC`, `epc`=0, state=BOOT.
  - `in_trap`=0, `halted`=0, `fetch_valid`=0.
- `rst` overrides every other input in the same edge, including in TRAP and HALT.
- Latency: next PC is visible on `pc` one edge after the controlling inputs are sampled. The first RUN-state fetch of `RESET_VEC` is in cycle 2 after reset deassertion.
- `epc` and `in_trap` update on the same edge as the redirect to `TRAP_VEC`.
- `in_trap`, `halted` and `fetch_valid` are decoded from registered state, so there is no combinational path from inputs to them.

## Configuration
- `NEXT_PC_OVF_TRAP_EN` defined:
  - Full trap logic: TRAP and HALT states, EPC register.
  - `eret` honoured as specified above.
- `NEXT_PC_OVF_TRAP_EN` undefined:
  - `ovf_trap`, `alu_overflow` and `eret` are ignored.
  - FSM reduces to BOOT → RUN.
  - `epc`, `in_trap` and `halted` are tied to 0.
  - `TRAP_VEC` is unused.

## Test plan
- Reset then 3 idle cycles with `RESET_VEC`=0 → `pc` sequence 0, 0 (BOOT), 4, 8; `fetch_valid` rises on cycle 2.
- At `pc`=0x40, `branch_eq`=1, `alu_zero`=1, `imm`=32'hFFFF_FFFE → `pc`=0x3C. Same stimulus with `alu_zero`=0 → `pc`=0x44.
- At `pc`=0x1000_0010, `jump`=1, `jidx`=26'h10 → `pc`=0x1000_0040. Same cycle with `jump_reg`=1, `rs_dat`=0x203 → `pc`=0x200 (jr wins, low bits cleared).
- Macro defined, at `pc`=0x80: `ovf_trap`=1, `alu_overflow`=1 → `pc`=0x180, `epc`=0x80, `in_trap`=1. Then `eret` → `pc`=0x80, `in_trap`=0.
- Macro defined, second overflow while in TRAP → `halted`=1, `pc` frozen across 10 cycles including `stall` toggles. Then `rst` → `pc`=`RESET_VEC`, state BOOT.
- `stall`=1 together with a trap condition → `pc`, `epc` and state unchanged. `pc`=0xFFFF_FFFC with no control → `pc`=0 (wrap).
